// File: rtl/flash_ctrl.sv
// flash_ctrl: turns read / page-program / sector-erase requests into SPI flash op sequences
// for the byte engine, with a page buffer for program data and WIP status polling.
module flash_ctrl #(
    parameter int P_POLL_MAX  = 65535,
    parameter int P_BUF_DEPTH = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_cmd_type,
    input  logic [23:0] i_cmd_addr,
    input  logic [8:0]  i_cmd_len,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [7:0]  i_wr_data,
    input  logic        i_wr_valid,
    output logic [7:0]  o_rd_data,
    output logic        o_rd_valid,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_spi_op_data,
    output logic        o_spi_op_len,
    output logic [1:0]  o_spi_op_type,
    output logic        o_spi_op_valid,
    input  logic        i_spi_ready,
    output logic [7:0]  o_spi_write_data,
    output logic [8:0]  o_spi_write_len,
    input  logic        i_spi_write_req,
    output logic [8:0]  o_spi_read_len,
    input  logic [7:0]  i_spi_read_data,
    input  logic        i_spi_read_valid
);
    localparam int CW = $clog2(P_POLL_MAX + 1);
    localparam int AW = $clog2(P_BUF_DEPTH);
    typedef enum logic [2:0] {IDLE, WREN, WREN_WAIT, MAIN, MAIN_WAIT, POLL, POLL_WAIT, DONE} state_t;
    state_t state_q, state_d;
    logic [1:0] type_q, type_d;
    logic [23:0] addr_q, addr_d;
    logic [8:0] len_q, len_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic busy_q, busy_d, stat_q, stat_d, wip_q, wip_d, err_q, err_d;
    logic bad, wait_done, wip_now, in_main, in_poll, is_wait;
    logic [7:0] buf_q [P_BUF_DEPTH];
    logic        cmd_ready_d, rd_valid_d, done_d, err_o_d, op_len_d, op_valid_d;
    logic [7:0]  rd_data_d, write_data_d, instr;
    logic [31:0] op_data_d;
    logic [1:0]  op_type_d;
    logic [8:0]  write_len_d, read_len_d;

    always_ff @(posedge i_clk) begin
        if (state_q == IDLE && i_wr_valid) buf_q[wptr_q] <= i_wr_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            type_q <= '0;
            addr_q <= '0;
            len_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q <= '0;
            busy_q <= 1'b0;
            stat_q <= 1'b0;
            wip_q <= 1'b0;
            err_q <= 1'b0;
            o_cmd_ready <= 1'b1;
            o_rd_data <= '0;
            o_rd_valid <= 1'b0;
            o_done <= 1'b0;
            o_err <= 1'b0;
            o_spi_op_data <= '0;
            o_spi_op_len <= 1'b0;
            o_spi_op_type <= '0;
            o_spi_op_valid <= 1'b0;
            o_spi_write_data <= '0;
            o_spi_write_len <= '0;
            o_spi_read_len <= '0;
        end else begin
            state_q <= state_d;
            type_q <= type_d;
            addr_q <= addr_d;
            len_q <= len_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q <= cnt_d;
            busy_q <= busy_d;
            stat_q <= stat_d;
            wip_q <= wip_d;
            err_q <= err_d;
            o_cmd_ready <= cmd_ready_d;
            o_rd_data <= rd_data_d;
            o_rd_valid <= rd_valid_d;
            o_done <= done_d;
            o_err <= err_o_d;
            o_spi_op_data <= op_data_d;
            o_spi_op_len <= op_len_d;
            o_spi_op_type <= op_type_d;
            o_spi_op_valid <= op_valid_d;
            o_spi_write_data <= write_data_d;
            o_spi_write_len <= write_len_d;
            o_spi_read_len <= read_len_d;
        end
    end

    assign bad = (i_cmd_type == 2'd3) || (i_cmd_type != 2'd2 && i_cmd_len == 9'd0);
    assign wait_done = busy_q && i_spi_ready;
    // A missing status byte is treated as still busy.
    assign wip_now = stat_q ? wip_q : i_spi_read_valid ? i_spi_read_data[0] : 1'b1;
    assign cnt_inc = (cnt_q == CW'(P_POLL_MAX)) ? cnt_q : cnt_q + 1'b1;
    assign is_wait = state_q inside {WREN_WAIT, MAIN_WAIT, POLL_WAIT};

    always_comb begin
        state_d = state_q;
        type_d = type_q;
        addr_d = addr_q;
        len_d = len_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d = cnt_q;
        stat_d = stat_q;
        wip_d = wip_q;
        err_d = err_q;
        case (state_q)
            IDLE: begin
                if (i_wr_valid) wptr_d = wptr_q + 1'b1;
                if (i_cmd_valid) begin
                    type_d = i_cmd_type;
                    addr_d = i_cmd_addr;
                    len_d = i_cmd_len;
                    wptr_d = '0;
                    cnt_d = '0;
                    err_d = bad;
                    state_d = bad ? DONE : (i_cmd_type == 2'd0) ? MAIN : WREN;
                end
            end
            WREN: state_d = i_spi_ready ? WREN_WAIT : WREN;
            WREN_WAIT: begin
                rptr_d = '0;
                state_d = wait_done ? MAIN : WREN_WAIT;
            end
            MAIN: state_d = i_spi_ready ? MAIN_WAIT : MAIN;
            MAIN_WAIT: begin
                if (i_spi_write_req) rptr_d = rptr_q + 1'b1;
                if (wait_done) begin
                    state_d = (type_q == 2'd0) ? DONE : POLL;
                    cnt_d = (type_q == 2'd0) ? cnt_q : cnt_inc;
                end
            end
            POLL: begin
                stat_d = 1'b0;
                state_d = i_spi_ready ? POLL_WAIT : POLL;
            end
            POLL_WAIT: begin
                if (i_spi_read_valid && !stat_q) begin
                    stat_d = 1'b1;
                    wip_d = i_spi_read_data[0];
                end
                if (wait_done) begin
                    state_d = (wip_now && cnt_q < CW'(P_POLL_MAX)) ? POLL : DONE;
                    err_d = wip_now;
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != state_q) ? 1'b0 : busy_q | (is_wait && !i_spi_ready);
    end

    // Outputs are registered from the next state so an op is presented the cycle after its state is chosen.
    always_comb begin
        in_main = state_d inside {MAIN, MAIN_WAIT};
        in_poll = state_d inside {POLL, POLL_WAIT};
        instr = (type_d == 2'd0) ? 8'h03 : (type_d == 2'd1) ? 8'h02 : 8'h20;
        cmd_ready_d = state_d == IDLE;
        op_valid_d = state_d inside {WREN, MAIN, POLL};
        op_data_d = (state_d == WREN) ? {8'h06, 24'h0} :
                    (state_d == POLL) ? {8'h05, 24'h0} :
                    (state_d == MAIN) ? {instr, addr_d} : '0;
        op_len_d = state_d == MAIN;
        op_type_d = (state_d == POLL || (state_d == MAIN && type_d == 2'd0)) ? 2'd1 :
                    (state_d == MAIN && type_d == 2'd1) ? 2'd2 : 2'd0;
        read_len_d = in_poll ? 9'd1 : (in_main && type_d == 2'd0) ? len_d : '0;
        write_len_d = (in_main && type_d == 2'd1) ? len_d : '0;
        write_data_d = (in_main && type_d == 2'd1) ? buf_q[rptr_d] : '0;
        rd_valid_d = state_q == MAIN_WAIT && type_q == 2'd0 && i_spi_read_valid;
        rd_data_d = rd_valid_d ? i_spi_read_data : o_rd_data;
        done_d = state_q == DONE;
        err_o_d = state_q == DONE && err_q;
    end
endmodule

// File: tb/tb_flash_ctrl.sv
// tb_flash_ctrl: scoreboard bench for flash_ctrl with a behavioural SPI engine model.
module tb_flash_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [1:0] cmd_type = '0;
    logic [23:0] cmd_addr = '0;
    logic [8:0] cmd_len = '0;
    logic cmd_valid = 1'b0, wr_valid = 1'b0, spi_ready = 1'b1, spi_write_req = 1'b0, spi_read_valid = 1'b0;
    logic [7:0] wr_data = '0, spi_read_data = '0;
    logic o_cmd_ready, o_rd_valid, o_done, o_err, o_spi_op_len, o_spi_op_valid;
    logic [7:0] o_rd_data, o_spi_write_data;
    logic [31:0] o_spi_op_data;
    logic [1:0] o_spi_op_type;
    logic [8:0] o_spi_write_len, o_spi_read_len;

    always #5 clk = ~clk;

    flash_ctrl #(.P_POLL_MAX(3)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_type(cmd_type), .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len), .i_cmd_valid(cmd_valid),
        .o_cmd_ready(o_cmd_ready), .i_wr_data(wr_data), .i_wr_valid(wr_valid),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_done(o_done), .o_err(o_err),
        .o_spi_op_data(o_spi_op_data), .o_spi_op_len(o_spi_op_len), .o_spi_op_type(o_spi_op_type),
        .o_spi_op_valid(o_spi_op_valid), .i_spi_ready(spi_ready),
        .o_spi_write_data(o_spi_write_data), .o_spi_write_len(o_spi_write_len), .i_spi_write_req(spi_write_req),
        .o_spi_read_len(o_spi_read_len), .i_spi_read_data(spi_read_data), .i_spi_read_valid(spi_read_valid)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        len;
        logic [1:0]  typ;
        logic [8:0]  rlen;
        logic [8:0]  wlen;
    } op_t;

    op_t exp_op[$];
    logic [7:0] exp_rd[$], exp_wr[$], src_rd[$], src_st[$];
    logic exp_done[$];
    int tests = 0, fails = 0, dones = 0;
    bit in_write = 0;

    function automatic op_t mk(input logic [31:0] d, input logic l, input logic [1:0] t, input logic [8:0] r, input logic [8:0] w);
        op_t o;
        o.data = d; o.len = l; o.typ = t; o.rlen = r; o.wlen = w;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic miss(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    // SPI engine model: accepts ops, goes busy, serves read bytes / write requests, then returns ready.
    initial begin
        op_t e;
        logic [1:0] ctype;
        logic [7:0] cinstr, b;
        int rl, wl;
        bit ab;
        forever begin
            @(negedge clk);
            if (rst_n && o_spi_op_valid && spi_ready) begin
                if (exp_op.size() == 0) miss("op_unexpected", o_spi_op_data);
                else begin
                    e = exp_op.pop_front();
                    chk("op_data", o_spi_op_data, e.data);
                    chk("op_len", {31'd0, o_spi_op_len}, {31'd0, e.len});
                    chk("op_type", {30'd0, o_spi_op_type}, {30'd0, e.typ});
                    if (e.typ == 2'd1) chk("read_len", {23'd0, o_spi_read_len}, {23'd0, e.rlen});
                    if (e.typ == 2'd2) chk("write_len", {23'd0, o_spi_write_len}, {23'd0, e.wlen});
                end
                ctype = o_spi_op_type;
                cinstr = o_spi_op_data[31:24];
                rl = int'(o_spi_read_len);
                wl = int'(o_spi_write_len);
                @(negedge clk);
                spi_ready = 1'b0;
                @(negedge clk);
                ab = 0;
                if (ctype == 2'd1) for (int i = 0; i < rl && !ab; i++) begin
                    if (!rst_n) ab = 1;
                    else begin
                        b = 8'h01;
                        if (cinstr == 8'h05) begin
                            if (src_st.size() != 0) b = src_st.pop_front();
                        end else if (src_rd.size() != 0) b = src_rd.pop_front();
                        spi_read_data = b;
                        spi_read_valid = 1'b1;
                        @(negedge clk);
                        spi_read_valid = 1'b0;
                        @(negedge clk);
                    end
                end
                if (ctype == 2'd2) for (int i = 0; i < wl && !ab; i++) begin
                    for (int k = 0; k < 16 && !ab; k++) begin
                        @(negedge clk);
                        if (!rst_n) ab = 1;
                    end
                    if (!ab) begin
                        if (exp_wr.size() == 0) miss("write_unexpected", {24'd0, o_spi_write_data});
                        else chk("write_data", {24'd0, o_spi_write_data}, {24'd0, exp_wr.pop_front()});
                        in_write = 1;
                        spi_write_req = 1'b1;
                        @(negedge clk);
                        spi_write_req = 1'b0;
                    end
                end
                spi_read_valid = 1'b0;
                spi_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (o_rd_valid) begin
            if (exp_rd.size() == 0) miss("rd_unexpected", {24'd0, o_rd_data});
            else chk("rd_data", {24'd0, o_rd_data}, {24'd0, exp_rd.pop_front()});
        end
        if (o_done) begin
            dones++;
            if (exp_done.size() == 0) miss("done_unexpected", {31'd0, o_err});
            else chk("done_err", {31'd0, o_err}, {31'd0, exp_done.pop_front()});
        end
    end

    task automatic issue(input logic [1:0] t, input logic [23:0] a, input logic [8:0] l, input bit bad);
        @(negedge clk);
        cmd_type = t;
        cmd_addr = a;
        cmd_len = l;
        cmd_valid = 1'b1;
        chk("cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (bad) begin
            chk("bad_no_op", {31'd0, o_spi_op_valid}, 32'd0);
            chk("bad_done_early", {31'd0, o_done}, 32'd0);
            @(negedge clk);
            chk("bad_done_2cyc", {31'd0, o_done}, 32'd1);
        end else chk("op_valid_1cyc", {31'd0, o_spi_op_valid}, 32'd1);
    endtask

    task automatic wait_done(input int n0);
        int c = 0;
        while (dones == n0 && c < 20000) begin
            @(negedge clk);
            c++;
        end
        chk("done_seen", {31'd0, dones != n0}, 32'd1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
        chk("rst_op_valid", {31'd0, o_spi_op_valid}, 32'd0);
        chk("rst_op_data", o_spi_op_data, 32'd0);
        chk("rst_op_type", {30'd0, o_spi_op_type}, 32'd0);
        chk("rst_done", {30'd0, o_done, o_err}, 32'd0);
        chk("rst_rd", {23'd0, o_rd_valid, o_rd_data}, 32'd0);
        chk("rst_write_data", {24'd0, o_spi_write_data}, 32'd0);
        chk("rst_lens", {13'd0, o_spi_op_len, o_spi_read_len, o_spi_write_len}, 32'd0);
    endtask

    initial begin
        int n;
        logic [7:0] rb [4];
        rb[0] = 8'hA1; rb[1] = 8'hA2; rb[2] = 8'hA3; rb[3] = 8'hA4;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // read 4 bytes
        exp_op.push_back(mk(32'h03012345, 1'b1, 2'd1, 9'd4, 9'd0));
        for (int i = 0; i < 4; i++) begin
            src_rd.push_back(rb[i]);
            exp_rd.push_back(rb[i]);
        end
        exp_done.push_back(1'b0);
        n = dones;
        issue(2'd0, 24'h012345, 9'd4, 0);
        wait_done(n);

        // load full page then program 256 bytes
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data = 8'(i);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        exp_op.push_back(mk(32'h06000000, 1'b0, 2'd0, 9'd0, 9'd0));
        exp_op.push_back(mk(32'h02000100, 1'b1, 2'd2, 9'd0, 9'd256));
        for (int i = 0; i < 3; i++) exp_op.push_back(mk(32'h05000000, 1'b0, 2'd1, 9'd1, 9'd0));
        for (int i = 0; i < 256; i++) exp_wr.push_back(8'(i));
        src_st.push_back(8'h01); src_st.push_back(8'h03); src_st.push_back(8'h00);
        exp_done.push_back(1'b0);
        n = dones;
        issue(2'd1, 24'h000100, 9'd256, 0);
        wait_done(n);

        // erase (len ignored), WIP 1 then 0
        exp_op.push_back(mk(32'h06000000, 1'b0, 2'd0, 9'd0, 9'd0));
        exp_op.push_back(mk(32'h20001000, 1'b1, 2'd0, 9'd0, 9'd0));
        for (int i = 0; i < 2; i++) exp_op.push_back(mk(32'h05000000, 1'b0, 2'd1, 9'd1, 9'd0));
        src_st.push_back(8'h01); src_st.push_back(8'hFE);
        exp_done.push_back(1'b0);
        n = dones;
        issue(2'd2, 24'h001000, 9'd0, 0);
        wait_done(n);

        // poll timeout with P_POLL_MAX=3
        exp_op.push_back(mk(32'h06000000, 1'b0, 2'd0, 9'd0, 9'd0));
        exp_op.push_back(mk(32'h20ABC000, 1'b1, 2'd0, 9'd0, 9'd0));
        for (int i = 0; i < 3; i++) begin
            exp_op.push_back(mk(32'h05000000, 1'b0, 2'd1, 9'd1, 9'd0));
            src_st.push_back(8'h01);
        end
        exp_done.push_back(1'b1);
        n = dones;
        issue(2'd2, 24'hABC000, 9'd1, 0);
        wait_done(n);

        // zero-length read / program and reserved type
        exp_done.push_back(1'b1);
        issue(2'd0, 24'h000010, 9'd0, 1);
        exp_done.push_back(1'b1);
        issue(2'd1, 24'h000020, 9'd0, 1);
        exp_done.push_back(1'b1);
        issue(2'd3, 24'h000030, 9'd8, 1);
        repeat (3) @(negedge clk);

        // reset during program data phase
        in_write = 0;
        exp_op.push_back(mk(32'h06000000, 1'b0, 2'd0, 9'd0, 9'd0));
        exp_op.push_back(mk(32'h02000200, 1'b1, 2'd2, 9'd0, 9'd2));
        exp_wr.push_back(8'h00); exp_wr.push_back(8'h01);
        issue(2'd1, 24'h000200, 9'd2, 0);
        n = 0;
        while (!in_write && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("write_started", {31'd0, in_write}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        repeat (2) @(negedge clk);
        exp_op.delete();
        exp_wr.delete();
        src_st.delete();
        rst_n = 1'b1;
        @(negedge clk);

        // read after reset completes normally
        exp_op.push_back(mk(32'h03ABCDEF, 1'b1, 2'd1, 9'd2, 9'd0));
        src_rd.push_back(8'h5A); src_rd.push_back(8'hC3);
        exp_rd.push_back(8'h5A); exp_rd.push_back(8'hC3);
        exp_done.push_back(1'b0);
        n = dones;
        issue(2'd0, 24'hABCDEF, 9'd2, 0);
        wait_done(n);
        repeat (5) @(negedge clk);

        chk("ops_left", exp_op.size(), 32'd0);
        chk("rd_left", exp_rd.size(), 32'd0);
        chk("wr_left", exp_wr.size(), 32'd0);
        chk("done_left", exp_done.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/flash_ctrl.md
# flash_ctrl

Command sequencer that sits directly upstream of the SPI byte engine (`spi_drive`). It turns user read, page-program and sector-erase requests into the required SPI flash instruction sequence:

- write enable (0x06);
- main instruction (0x03 / 0x02 / 0x20) with 24-bit address;
- read-status (0x05) polling of WIP.

It holds a 256-byte page buffer that feeds program data to the engine. It forwards read data back to the user.

## Interface
Parameters:
- P_POLL_MAX, 65535, maximum status reads before timeout error
- P_BUF_DEPTH, 256, page buffer depth in bytes (fixed 8-bit data)

Ports:
- i_clk  in  1  system clock; single clock domain
- i_rst_n  in  1  reset, asynchronous, active-low
- i_cmd_type  in  2  0 read, 1 page program, 2 sector erase, 3 reserved
- i_cmd_addr  in  24  flash byte address
- i_cmd_len  in  9  byte count for read/program, 1..256
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  high in IDLE only
- i_wr_data  in  8  page-buffer load data
- i_wr_valid  in  1  load strobe, accepted only while o_cmd_ready=1
- o_rd_data  out  8  read byte to user
- o_rd_valid  out  1  one-cycle strobe per read byte
- o_done  out  1  one-cycle pulse at command end
- o_err  out  1  valid with o_done: 1 = timeout, zero length or reserved type
- o_spi_op_data  out  32  {instr, addr} or {instr, 24'h0}
- o_spi_op_len  out  1  0 = 8-bit op, 1 = 32-bit op
- o_spi_op_type  out  2  0 instr only, 1 read, 2 write
- o_spi_op_valid  out  1  op request to engine
- i_spi_ready  in  1  engine idle/ready
- o_spi_write_data  out  8  current program byte, valid before each write request
- o_spi_write_len  out  9  program byte count
- i_spi_write_req  in  1  engine consumed o_spi_write_data
- o_spi_read_len  out  9  read byte count
- i_spi_read_data  in  8  engine read byte
- i_spi_read_valid  in  1  engine read strobe

## Operation

**States:**
- IDLE: o_cmd_ready=1.
  - i_wr_valid writes i_wr_data to buf[wptr]; wptr increments and wraps at 256.
  - Handshake i_cmd_valid & o_cmd_ready latches type, address and length, and clears wptr.
- Command acceptance:
  - Reserved type, or len=0 for read/program → DONE with err=1.
  - Read → MAIN.
  - Program or erase → WREN.
- WREN: op={0x06,24'h0}, len=0, type=0. After handshake → WREN_WAIT → MAIN.
- MAIN:
  - Read: {0x03,addr}, type=1, read_len=len.
  - Program: {0x02,addr}, type=2, write_len=len.
  - Erase: {0x20,addr}, type=0.
  - All use len=1 (32-bit op).
  - Next: MAIN_WAIT. Read → DONE; program/erase → POLL.
- POLL: op={0x05,24'h0}, len=0, type=1, read_len=1. Next: POLL_WAIT. The first i_spi_read_valid byte is the status; bit0 is WIP.
  - WIP=0 → DONE with err=0.
  - WIP=1 and poll count < P_POLL_MAX → POLL again.
  - Otherwise → DONE with err=1.
- DONE: o_done=1 for one cycle → IDLE.

**Engine handshake:**
- o_spi_op_valid is held high until a cycle where i_spi_ready=1; it drops the next cycle.
- Every *_WAIT state first waits for i_spi_ready=0, then exits on the first cycle with i_spi_ready=1.

**Read path:**
- In MAIN_WAIT for a read, each i_spi_read_valid is registered to o_rd_data/o_rd_valid with 1-cycle latency.
- Status bytes are never forwarded to o_rd_*.

**Write path:**
- rptr resets to 0 at MAIN entry.
- o_spi_write_data = buf[rptr] is prefetched so it is stable before the engine requests it.
- On i_spi_write_req, rptr increments and the next byte appears within 2 cycles. The engine spaces write requests ≥16 cycles apart.

**Buffer and length rules:**
- Length 256 is encoded as 9'd256.
- The buffer is not cleared between commands.
- Program of N bytes uses buf[0..N-1].

**Reset mid-operation:** all state is cleared immediately to IDLE, and any in-flight op is abandoned.

## Timing
- Reset values:
  - o_cmd_ready=1.
  - All other outputs 0.
  - Pointers, poll count and state = IDLE.
- All outputs are registered.
- o_done asserts exactly 1 cycle after the terminating condition.
- Command accept → o_spi_op_valid high: 1 cycle.
- Zero-length or reserved command → o_done with err=1: 2 cycles after accept, with no SPI op issued.
- i_wr_valid outside IDLE is ignored.
- i_cmd_valid and i_wr_valid in the same IDLE cycle: both are accepted; the byte is written, then wptr is cleared.
- Poll counter saturates; it is cleared at command accept.

## Test plan
- **Read:** cmd read addr 0x012345 len 4; engine model returns A1 A2 A3 A4 → one op {0x03012345} type 1 read_len 4; four o_rd_valid pulses with A1..A4; o_done err=0.
- **Program:** load bytes 0x00..0xFF, cmd program addr 0x000100 len 256; WIP returns 1,1,0 → ops 0x06, {0x02000100} with 256 write_req each seeing bytes 0x00..0xFF in order; three 0x05 ops; o_done err=0.
- **Erase:** cmd erase addr 0x001000 → ops 0x06, {0x20001000} type 0, polls until WIP=0; no o_rd_valid.
- **Timeout:** P_POLL_MAX=3, WIP stuck at 1 → exactly 3 status ops; o_done err=1.
- **Boundary:** len=0 read → o_done err=1, no o_spi_op_valid; type 3 → same.
- **Reset mid-command:** i_rst_n low during MAIN_WAIT of a program → all outputs at reset values; o_cmd_ready=1; a new read completes normally.
